// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad front end: command codes,
// scan FSM state encoding and the keypad position-to-code map.
package calc_pkg;

  localparam logic [3:0] CMD_ADD  = 4'hA;
  localparam logic [3:0] CMD_SUB  = 4'hB;
  localparam logic [3:0] CMD_MUL  = 4'hC;
  localparam logic [3:0] CMD_CLR  = 4'hD;
  localparam logic [3:0] CMD_EQ   = 4'hE;
  localparam logic [3:0] CMD_IDLE = 4'hF;

  typedef enum logic [2:0] {
    ST_SCAN         = 3'd0,
    ST_DEBOUNCE     = 3'd1,
    ST_EMIT         = 3'd2,
    ST_WAIT_RELEASE = 3'd3,
    ST_REPEAT       = 3'd4
  } scan_state_t;

  // r3c3 is unpopulated on the board and maps to idle.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = CMD_ADD;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = CMD_SUB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = CMD_MUL;
      4'b11_00: code = CMD_CLR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = CMD_EQ;
      default:  code = CMD_IDLE;
    endcase
    return code;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous keypad inputs, cleared to zero
// by the asynchronous active-low reset.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/calc_keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and ghost-key rejection feeding calc_top.cmd.
// Optional auto-repeat of digit keys is built when CALC_KEYPAD_REPEAT_EN is defined.
module calc_keypad_scan
  import calc_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int CMD_HOLD       = 10,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_sense,
  output logic [3:0] col_drive,
  output logic [3:0] cmd,
  output logic       key_valid,
  output logic [2:0] EA
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam int HOLD_W = $clog2(CMD_HOLD + 1);

  // Stage p0: synchronised rows
  logic [3:0] row_p0;

  keypad_sync #(.WIDTH(4)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (row_sense),
    .q     (row_p0)
  );

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col;
  logic [1:0]       acc_n;
  logic [1:0]       acc_row;
  logic [1:0]       acc_col;
  logic [3:0]       cand_p1;
  logic             vld_p1;

  logic [3:0] pressed;
  logic [2:0] col_hits;
  logic [1:0] hit_row;
  logic [1:0] base_n;
  logic [2:0] sum_n;
  logic [1:0] next_n;
  logic [1:0] next_row;
  logic [1:0] next_col;

  assign pressed   = ~row_p0;
  assign col_drive = ~(4'b0001 << col);

  // Hit count saturates at 2: two or more keys in one scan is ghost/rollover.
  always_comb begin
    col_hits = 3'd0;
    hit_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (pressed[r]) begin
        col_hits = col_hits + 3'd1;
        hit_row  = 2'(r);
      end
    end
    base_n   = (col == 2'd0) ? 2'd0 : acc_n;
    sum_n    = 3'(base_n) + col_hits;
    next_n   = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    next_row = (col_hits != 3'd0) ? hit_row : acc_row;
    next_col = (col_hits != 3'd0) ? col : acc_col;
  end

  // Stage p1: scan result. Sampling in the last slot cycle means the rows seen
  // were driven by this column two cycles earlier, so SCAN_DIV must be >= 3.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      col     <= 2'd0;
      acc_n   <= 2'd0;
      acc_row <= 2'd0;
      acc_col <= 2'd0;
      cand_p1 <= CMD_IDLE;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
        div_cnt <= '0;
        col     <= col + 2'd1;
        acc_n   <= next_n;
        acc_row <= next_row;
        acc_col <= next_col;
        if (col == 2'd3) begin
          vld_p1  <= 1'b1;
          cand_p1 <= (next_n == 2'd1) ? key_code(next_row, next_col) : CMD_IDLE;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  scan_state_t       state;
  logic [3:0]        latched;
  logic [CNT_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              agree;
  logic              deb_done;

  assign agree    = vld_p1 && (cand_p1 == latched);
  assign deb_done = (int'(deb_cnt) + 1) >= DEBOUNCE_SCANS;
  assign EA       = 3'(state);

`ifdef CALC_KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_active;
`endif

  // Stage p2: command FSM; deb_cnt doubles as the release counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_SCAN;
      latched   <= CMD_IDLE;
      cmd       <= CMD_IDLE;
      key_valid <= 1'b0;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
`ifdef CALC_KEYPAD_REPEAT_EN
      rpt_cnt    <= '0;
      rpt_active <= 1'b0;
`endif
    end else begin
      case (state)
        ST_SCAN: begin
          if (vld_p1 && cand_p1 != CMD_IDLE) begin
            state   <= ST_DEBOUNCE;
            deb_cnt <= CNT_W'(1);
            latched <= cand_p1;
          end
        end
        ST_DEBOUNCE: begin
          if (vld_p1) begin
            if (agree) begin
              deb_cnt <= deb_cnt + 1'b1;
              if (deb_done) begin
                state     <= ST_EMIT;
                cmd       <= latched;
                key_valid <= 1'b1;
                hold_cnt  <= '0;
`ifdef CALC_KEYPAD_REPEAT_EN
                rpt_cnt   <= '0;
`endif
              end
            end else begin
              state <= ST_SCAN;
            end
          end
        end
        ST_EMIT: begin
`ifdef CALC_KEYPAD_REPEAT_EN
          // Keep counting held scans so the repeat cadence is measured from emission.
          if (agree) rpt_cnt <= rpt_cnt + 1'b1;
`endif
          if (int'(hold_cnt) >= CMD_HOLD - 1) begin
            cmd       <= CMD_IDLE;
            key_valid <= 1'b0;
            deb_cnt   <= '0;
`ifdef CALC_KEYPAD_REPEAT_EN
            state     <= rpt_active ? ST_REPEAT : ST_WAIT_RELEASE;
`else
            state     <= ST_WAIT_RELEASE;
`endif
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_WAIT_RELEASE: begin
          if (vld_p1) begin
            if (cand_p1 == CMD_IDLE) begin
              if (deb_done) begin
                state   <= ST_SCAN;
                deb_cnt <= '0;
              end else begin
                deb_cnt <= deb_cnt + 1'b1;
              end
`ifdef CALC_KEYPAD_REPEAT_EN
              rpt_cnt <= '0;
`endif
            end else begin
              deb_cnt <= '0;
`ifdef CALC_KEYPAD_REPEAT_EN
              if (agree && is_digit(latched)) begin
                if ((int'(rpt_cnt) + 1) >= REPEAT_DELAY) begin
                  state      <= ST_REPEAT;
                  rpt_cnt    <= '0;
                  rpt_active <= 1'b1;
                end else begin
                  rpt_cnt <= rpt_cnt + 1'b1;
                end
              end else begin
                rpt_cnt <= '0;
              end
`endif
            end
          end
        end
`ifdef CALC_KEYPAD_REPEAT_EN
        ST_REPEAT: begin
          if (vld_p1) begin
            if (cand_p1 == CMD_IDLE) begin
              rpt_cnt <= '0;
              if (deb_done) begin
                state      <= ST_SCAN;
                deb_cnt    <= '0;
                rpt_active <= 1'b0;
              end else begin
                deb_cnt <= deb_cnt + 1'b1;
              end
            end else if (agree) begin
              deb_cnt <= '0;
              if ((int'(rpt_cnt) + 1) >= REPEAT_RATE) begin
                state     <= ST_EMIT;
                cmd       <= latched;
                key_valid <= 1'b1;
                hold_cnt  <= '0;
                rpt_cnt   <= '0;
              end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
              end
            end else begin
              deb_cnt    <= '0;
              rpt_cnt    <= '0;
              rpt_active <= 1'b0;
              state      <= ST_WAIT_RELEASE;
            end
          end
        end
`endif
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule
